// File: rtl/fp16_align.sv
// Exponent-alignment front end for an fp16 adder: unpacks two operands, orders them by
// exponent and right-shifts the smaller significand with sticky. Optional macro: FP16_ALIGN_FASTPATH_EN.
module fp16_align #(
    parameter int MB = 11,
    parameter int EB = 5
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [MB+EB-1:0] IN_A,
    input  logic [MB+EB-1:0] IN_B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [MB+2:0]    OUT_MANT_L,
    output logic [MB+2:0]    OUT_MANT_S,
    output logic [EB-1:0]    OUT_EXP,
    output logic             OUT_SIGN_L,
    output logic             OUT_SIGN_S,
    output logic             OUT_SWAP,
    output logic             OUT_SPECIAL
);

    localparam int KW = $clog2(MB + 4);
    localparam int SW = (EB > KW) ? EB : KW;
    localparam logic [SW-1:0] KMAX = SW'(MB + 3);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [MB+2:0]   mant_l_q, mant_l_d;
    logic [MB+2:0]   mant_s_q, mant_s_d;
    logic [EB-1:0]   exp_q, exp_d;
    logic            sign_l_q, sign_l_d;
    logic            sign_s_q, sign_s_d;
    logic            swap_q, swap_d;
    logic            special_q, special_d;
    logic [KW-1:0]   k_q, k_d;

    logic            accept;
    logic [EB-1:0]   exp_a_raw, exp_b_raw, exp_a_eff, exp_b_eff;
    logic [MB+2:0]   sig_a, sig_b, sig_s_in;
    logic            swap_in, special_in;
    logic [SW-1:0]   d_ext;
    logic [KW-1:0]   k_in;

    assign accept = IN_VALID && IN_READY;

    // Unpack: denormals use hidden bit 0 and effective exponent 1
    always_comb begin
        exp_a_raw = IN_A[MB+EB-2:MB-1];
        exp_b_raw = IN_B[MB+EB-2:MB-1];
        exp_a_eff = (exp_a_raw == '0) ? EB'(1) : exp_a_raw;
        exp_b_eff = (exp_b_raw == '0) ? EB'(1) : exp_b_raw;
        sig_a     = {(exp_a_raw != '0), IN_A[MB-2:0], 3'b000};
        sig_b     = {(exp_b_raw != '0), IN_B[MB-2:0], 3'b000};
        swap_in   = (exp_b_eff > exp_a_eff);
        special_in = (exp_a_raw == '1) || (exp_b_raw == '1);
        sig_s_in  = swap_in ? sig_a : sig_b;
        d_ext     = swap_in ? (SW'(exp_b_eff) - SW'(exp_a_eff))
                            : (SW'(exp_a_eff) - SW'(exp_b_eff));
        k_in      = (d_ext >= KMAX) ? KMAX[KW-1:0] : d_ext[KW-1:0];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            mant_l_q  <= '0;
            mant_s_q  <= '0;
            exp_q     <= '0;
            sign_l_q  <= 1'b0;
            sign_s_q  <= 1'b0;
            swap_q    <= 1'b0;
            special_q <= 1'b0;
            k_q       <= '0;
        end else begin
            state_q   <= state_d;
            mant_l_q  <= mant_l_d;
            mant_s_q  <= mant_s_d;
            exp_q     <= exp_d;
            sign_l_q  <= sign_l_d;
            sign_s_q  <= sign_s_d;
            swap_q    <= swap_d;
            special_q <= special_d;
            k_q       <= k_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef FP16_ALIGN_FASTPATH_EN
                    if (k_in == '0 || special_in || d_ext >= KMAX) state_d = DONE;
                    else                                           state_d = SHIFT;
`else
                    if (k_in == '0 || special_in) state_d = DONE;
                    else                          state_d = SHIFT;
`endif
                end
            end
            SHIFT:   if (k_q == KW'(1)) state_d = DONE;
            DONE:    if (OUT_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values; registers hold unless loading or shifting
    always_comb begin
        mant_l_d  = mant_l_q;
        mant_s_d  = mant_s_q;
        exp_d     = exp_q;
        sign_l_d  = sign_l_q;
        sign_s_d  = sign_s_q;
        swap_d    = swap_q;
        special_d = special_q;
        k_d       = k_q;
        if (state_q == IDLE && accept) begin
            mant_l_d  = swap_in ? sig_b : sig_a;
            mant_s_d  = sig_s_in;
            exp_d     = swap_in ? exp_b_eff : exp_a_eff;
            sign_l_d  = swap_in ? IN_B[MB+EB-1] : IN_A[MB+EB-1];
            sign_s_d  = swap_in ? IN_A[MB+EB-1] : IN_B[MB+EB-1];
            swap_d    = swap_in;
            special_d = special_in;
            k_d       = special_in ? '0 : k_in;
`ifdef FP16_ALIGN_FASTPATH_EN
            if (!special_in && d_ext >= KMAX) begin
                mant_s_d = {{(MB+2){1'b0}}, |sig_s_in};
                k_d      = '0;
            end
`endif
        end else if (state_q == SHIFT) begin
            mant_s_d = {1'b0, mant_s_q[MB+2:2], mant_s_q[1] | mant_s_q[0]};
            k_d      = k_q - KW'(1);
        end
    end

    // Outputs
    always_comb begin
        IN_READY  = (state_q == IDLE);
        OUT_VALID = (state_q == DONE);
    end

    assign OUT_MANT_L  = mant_l_q;
    assign OUT_MANT_S  = mant_s_q;
    assign OUT_EXP     = exp_q;
    assign OUT_SIGN_L  = sign_l_q;
    assign OUT_SIGN_S  = sign_s_q;
    assign OUT_SWAP    = swap_q;
    assign OUT_SPECIAL = special_q;

endmodule

// File: tb/tb_fp16_align.sv
// Directed bench for fp16_align: hand-computed alignment results, latencies, stall and reset behaviour.
module tb_fp16_align;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic [15:0] IN_A, IN_B;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [13:0] OUT_MANT_L, OUT_MANT_S;
    logic [4:0]  OUT_EXP;
    logic        OUT_SIGN_L, OUT_SIGN_S, OUT_SWAP, OUT_SPECIAL;

    int total = 0;
    int bad   = 0;
    int lat;
    int seen;
    logic [13:0] hold_s;

`ifdef FP16_ALIGN_FASTPATH_EN
    localparam int LAT_FAR = 1;
`else
    localparam int LAT_FAR = 15;
`endif

    fp16_align #(.MB(11), .EB(5)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_A(IN_A), .IN_B(IN_B),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_MANT_L(OUT_MANT_L), .OUT_MANT_S(OUT_MANT_S),
        .OUT_EXP(OUT_EXP), .OUT_SIGN_L(OUT_SIGN_L), .OUT_SIGN_S(OUT_SIGN_S),
        .OUT_SWAP(OUT_SWAP), .OUT_SPECIAL(OUT_SPECIAL)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [15:0] a, input logic [15:0] b);
        @(negedge CLK);
        IN_A = a;
        IN_B = b;
        IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    // Latency counts edges from the accepting edge up to the one that raises OUT_VALID
    task automatic wait_valid(output int n);
        n = 1;
        while (!OUT_VALID && n < 40) begin
            @(posedge CLK);
            #1;
            n++;
        end
    endtask

    task automatic release_out();
        @(negedge CLK);
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        check("post_ready_valid", 32'(OUT_VALID), 32'd0);
        check("post_ready_inready", 32'(IN_READY), 32'd1);
    endtask

    initial begin
        RST_N = 1'b0;
        IN_VALID = 1'b0;
        IN_A = '0;
        IN_B = '0;
        OUT_READY = 1'b0;
        #12;
        check("rst_inready", 32'(IN_READY), 32'd1);
        check("rst_valid", 32'(OUT_VALID), 32'd0);
        check("rst_mant_l", 32'(OUT_MANT_L), 32'h0);
        check("rst_mant_s", 32'(OUT_MANT_S), 32'h0);
        check("rst_special", 32'(OUT_SPECIAL), 32'd0);
        check("rst_swap", 32'(OUT_SWAP), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // 1.0 vs 0.5
        accept(16'h3C00, 16'h3800);
        wait_valid(lat);
        check("c1_lat", 32'(lat), 32'd2);
        check("c1_exp", 32'(OUT_EXP), 32'd15);
        check("c1_mant_l", 32'(OUT_MANT_L), 32'h2000);
        check("c1_mant_s", 32'(OUT_MANT_S), 32'h1000);
        check("c1_swap", 32'(OUT_SWAP), 32'd0);
        release_out();

        // Swapped order
        accept(16'h3800, 16'h3C00);
        wait_valid(lat);
        check("c2_lat", 32'(lat), 32'd2);
        check("c2_exp", 32'(OUT_EXP), 32'd15);
        check("c2_mant_l", 32'(OUT_MANT_L), 32'h2000);
        check("c2_mant_s", 32'(OUT_MANT_S), 32'h1000);
        check("c2_swap", 32'(OUT_SWAP), 32'd1);
        release_out();

        // Equal exponents
        accept(16'h4000, 16'h4000);
        wait_valid(lat);
        check("c3_lat", 32'(lat), 32'd1);
        check("c3_exp", 32'(OUT_EXP), 32'd16);
        check("c3_mant_l", 32'(OUT_MANT_L), 32'h2000);
        check("c3_mant_s", 32'(OUT_MANT_S), 32'h2000);
        check("c3_swap", 32'(OUT_SWAP), 32'd0);
        release_out();

        // Far-apart exponents with a denormal: only sticky survives
        accept(16'h3C00, 16'h0001);
        wait_valid(lat);
        check("c4_lat", 32'(lat), 32'(LAT_FAR));
        check("c4_exp", 32'(OUT_EXP), 32'd15);
        check("c4_mant_l", 32'(OUT_MANT_L), 32'h2000);
        check("c4_mant_s", 32'(OUT_MANT_S), 32'h0001);
        release_out();

        // d=4 with a low frac bit folding into sticky
        accept(16'h3C00, 16'h2C01);
        wait_valid(lat);
        check("c5_lat", 32'(lat), 32'd5);
        check("c5_exp", 32'(OUT_EXP), 32'd15);
        check("c5_mant_s", 32'(OUT_MANT_S), 32'h0201);
        release_out();

        // Signs follow the L/S ordering
        accept(16'hC000, 16'h3C00);
        wait_valid(lat);
        check("c6_lat", 32'(lat), 32'd2);
        check("c6_sign_l", 32'(OUT_SIGN_L), 32'd1);
        check("c6_sign_s", 32'(OUT_SIGN_S), 32'd0);
        check("c6_mant_s", 32'(OUT_MANT_S), 32'h1000);
        release_out();

        // Infinity: pass-through, then stall in DONE with junk on the input side
        accept(16'h7C00, 16'h3C00);
        wait_valid(lat);
        check("c7_lat", 32'(lat), 32'd1);
        check("c7_special", 32'(OUT_SPECIAL), 32'd1);
        check("c7_exp", 32'(OUT_EXP), 32'd31);
        check("c7_mant_l", 32'(OUT_MANT_L), 32'h2000);
        check("c7_mant_s", 32'(OUT_MANT_S), 32'h2000);
        hold_s = OUT_MANT_S;
        IN_A = 16'h1234;
        IN_B = 16'h5678;
        IN_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            check("c7_hold_valid", 32'(OUT_VALID), 32'd1);
            check("c7_hold_inready", 32'(IN_READY), 32'd0);
            check("c7_hold_mant_s", 32'(OUT_MANT_S), 32'(hold_s));
            check("c7_hold_exp", 32'(OUT_EXP), 32'd31);
        end
        IN_VALID = 1'b0;
        release_out();

        // Reset during SHIFT discards the pair
        accept(16'h3C00, 16'h0001);
        repeat (3) @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check("c8_rst_valid", 32'(OUT_VALID), 32'd0);
        check("c8_rst_inready", 32'(IN_READY), 32'd1);
        check("c8_rst_mant_s", 32'(OUT_MANT_S), 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1;
            if (OUT_VALID) seen++;
        end
        check("c8_no_stale", 32'(seen), 32'd0);
        check("c8_inready_after", 32'(IN_READY), 32'd1);

        // Normal operation resumes after reset
        accept(16'h3C00, 16'h3800);
        wait_valid(lat);
        check("c9_lat", 32'(lat), 32'd2);
        check("c9_mant_s", 32'(OUT_MANT_S), 32'h1000);
        release_out();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp16_align.md
FP16_ALIGN -- requirements
Module: fp16_align

Interface
REQ-001 SHALL have parameter MB, default 11: significand bits including hidden bit.
REQ-002 SHALL have parameter EB, default 5: exponent bits.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port IN_VALID  input  1  operand pair valid.
REQ-006 SHALL have port IN_READY  output  1  block can accept a pair.
REQ-007 SHALL have ports IN_A and IN_B  input  MB+EB each  raw fp16 operands {sign, exp, frac}.
REQ-008 SHALL have port OUT_VALID  output  1  aligned result valid.
REQ-009 SHALL have port OUT_READY  input  1  consumer accepts the result.
REQ-010 SHALL have ports OUT_MANT_L and OUT_MANT_S  output  MB+3 each  larger-exponent and smaller-exponent significands, format {sig[MB-1:0], G, R, S}.
REQ-011 SHALL have port OUT_EXP  output  EB  common (larger) exponent.
REQ-012 SHALL have ports OUT_SIGN_L and OUT_SIGN_S  output  1 each  signs matching the L and S significands.
REQ-013 SHALL have port OUT_SWAP  output  1  high when B has the larger exponent.
REQ-014 SHALL have port OUT_SPECIAL  output  1  either operand has an all-ones exponent (Inf/NaN).

Function
REQ-015 SHALL use FSM states IDLE, SHIFT and DONE; IN_READY is high only in IDLE.
REQ-016 SHALL accept a pair on IN_VALID && IN_READY at a rising edge, unpack both operands and register them.
REQ-017 SHALL unpack as follows: exp==0 gives hidden bit 0 and effective exponent 1; otherwise hidden bit 1 and the stored exponent.
REQ-018 SHALL make operand L the one with the larger effective exponent; on a tie L=A, S=B and OUT_SWAP=0.
REQ-019 SHALL load the significands as {hidden, frac, 3'b000} and compute d = expL - expS, with shift count k = min(d, MB+3).
REQ-020 SHALL go from accept to DONE when k==0 or OUT_SPECIAL is set, and otherwise to SHIFT.
REQ-021 SHALL, in SHIFT, shift S right by one bit per cycle as S_next = {0, S[MB+2:2], S[1]|S[0]} and decrement k; when k reaches 0 the FSM moves to DONE.
REQ-022 SHALL reach DONE k+1 cycles after accept, with OUT_VALID high in DONE only.
REQ-023 SHALL hold all outputs stable in DONE while OUT_READY is low.
REQ-024 SHALL leave DONE for IDLE on OUT_READY; the next accept occurs no earlier than the following cycle.
REQ-025 SHALL, when OUT_SPECIAL is set, do no shifting and pass the unpacked operands through unchanged.
REQ-026 SHALL ignore IN_A, IN_B and IN_VALID outside IDLE.

Reset
REQ-027 SHALL, while RST_N is low, force state to IDLE, OUT_VALID to 0, and all data outputs and OUT_SWAP/OUT_SPECIAL to 0.
REQ-028 SHALL hold IN_READY at 1 while RST_N is low and after release.
REQ-029 SHALL discard any in-flight pair when reset is asserted mid-SHIFT or mid-DONE, producing no output for it.

Configuration
REQ-030 SHALL, when macro FP16_ALIGN_FASTPATH_EN is defined and d >= MB+3, set S to {0..0, sticky} at accept (sticky = OR of all S bits) and go directly to DONE, giving a latency of 1 cycle.
REQ-031 SHALL, when FP16_ALIGN_FASTPATH_EN is undefined, handle d >= MB+3 by iterating MB+3 SHIFT cycles, giving a latency of MB+4 cycles; result values SHALL be identical in both builds.

Verification
REQ-032 SHALL cover: A=0x3C00, B=0x3800 -> OUT_VALID 2 cycles after accept, OUT_EXP=15, OUT_MANT_L=0x2000, OUT_MANT_S=0x1000, OUT_SWAP=0.
REQ-033 SHALL cover: A=0x3800, B=0x3C00 -> same values with OUT_SWAP=1.
REQ-034 SHALL cover: A=B=0x4000 -> OUT_VALID 1 cycle after accept, OUT_EXP=16, both significands 0x2000.
REQ-035 SHALL cover: A=0x3C00, B=0x0001 -> OUT_MANT_S=0x0001 (sticky only); latency 15 cycles without the macro, 1 cycle with it.
REQ-036 SHALL cover: A=0x7C00, B=0x3C00 -> OUT_SPECIAL=1 and OUT_VALID 1 cycle after accept; and OUT_READY held low 3 cycles in DONE -> outputs stable, IN_READY=0.
REQ-037 SHALL cover: RST_N pulsed low during SHIFT -> OUT_VALID=0 immediately, IN_READY=1, and no stale result after release.
